// File: rtl/rate_divided_aggregator.sv
// rate_divided_aggregator: power-of-two rate divider feeding CH result lanes.
// A base counter produces a tick every BASE_DIV enabled cycles; lane i fires
// every 2^i ticks and either samples the latest event (MODE=0) or reports the
// sum of events since its previous fire (MODE=1).
// Build option: define SATURATE_EN to clamp MODE=1 sums at the signed limits
// instead of wrapping.
module rate_divided_aggregator #(
  parameter int WIDTH    = 32,
  parameter int CH       = 4,
  parameter int BASE_DIV = 10000000,
  parameter int MODE     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    a_valid,
  input  logic signed [WIDTH-1:0] a,
  output logic [CH*WIDTH-1:0]     result,
  output logic [CH-1:0]           valid
);

  localparam int CW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam int KW = (CH > 1) ? CH - 1 : 1;
  localparam logic [CW-1:0] LAST = CW'(BASE_DIV - 1);

  logic [CW-1:0]           base_cnt;
  logic [KW-1:0]           k;
  logic                    tick;
  logic [CH-1:0]           fire;
  logic signed [WIDTH-1:0] hold;
  logic signed [WIDTH-1:0] acc [CH];
  logic signed [WIDTH-1:0] in_term;

  assign tick    = en && (base_cnt == LAST);
  assign in_term = a_valid ? a : '0;

  // Signed add used for both the running accumulator and the fire-time sum.
  function automatic logic signed [WIDTH-1:0] add(input logic signed [WIDTH-1:0] x,
                                                  input logic signed [WIDTH-1:0] y);
`ifdef SATURATE_EN
    logic signed [WIDTH:0] s;
    s = {x[WIDTH-1], x} + {y[WIDTH-1], y};
    if (s[WIDTH] != s[WIDTH-1])
      add = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      add = s[WIDTH-1:0];
`else
    add = x + y;
`endif
  endfunction

  // Lane i fires on a tick whose pre-increment k has its low i bits all set.
  always_comb begin
    fire = '0;
    for (int i = 0; i < CH; i++) begin
      fire[i] = tick && ((k & KW'((1 << i) - 1)) == KW'((1 << i) - 1));
    end
  end

  // Base divider and tick counter; both freeze while en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_cnt <= '0;
      k        <= '0;
    end else if (en) begin
      if (tick) begin
        base_cnt <= '0;
        k        <= k + KW'(1);
      end else begin
        base_cnt <= base_cnt + CW'(1);
      end
    end
  end

  // Event capture, per-lane accumulation and registered lane outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold   <= '0;
      result <= '0;
      valid  <= '0;
      for (int i = 0; i < CH; i++) acc[i] <= '0;
    end else begin
      valid <= '0;
      if (en) begin
        if (a_valid) hold <= a;
        for (int i = 0; i < CH; i++) begin
          if (fire[i]) begin
            valid[i] <= 1'b1;
            if (MODE == 0) begin
              result[i*WIDTH +: WIDTH] <= a_valid ? a : hold;
            end else begin
              result[i*WIDTH +: WIDTH] <= add(acc[i], in_term);
              acc[i]                   <= '0;
            end
          end else if (MODE != 0) begin
            acc[i] <= add(acc[i], in_term);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rate_divided_aggregator.sv
// Bench for rate_divided_aggregator: three instances (32-bit sum, 16-bit
// sample-and-hold, 8-bit overflow) share control inputs and are checked every
// cycle against a counting model, plus literal spot checks.
module tb_rate_divided_aggregator;

  localparam int BD = 4;
`ifdef SATURATE_EN
  localparam longint OVF_EXP = 127;
`else
  localparam longint OVF_EXP = -112;
`endif

  logic clk = 1'b0, rst = 1'b0, en = 1'b0, a_valid = 1'b0;
  logic signed [31:0] a_s = '0;
  logic signed [15:0] a_h = '0;
  logic signed [7:0]  a_o = '0;
  logic [127:0] res_s;  logic [3:0] vld_s;
  logic [47:0]  res_h;  logic [2:0] vld_h;
  logic [15:0]  res_o;  logic [1:0] vld_o;
  int tests = 0, fails = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  rate_divided_aggregator #(.WIDTH(32), .CH(4), .BASE_DIV(BD), .MODE(1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .a_valid(a_valid), .a(a_s), .result(res_s), .valid(vld_s));
  rate_divided_aggregator #(.WIDTH(16), .CH(3), .BASE_DIV(BD), .MODE(0)) dut_h (
    .clk(clk), .rst(rst), .en(en), .a_valid(a_valid), .a(a_h), .result(res_h), .valid(vld_h));
  rate_divided_aggregator #(.WIDTH(8), .CH(2), .BASE_DIV(BD), .MODE(1)) dut_o (
    .clk(clk), .rst(rst), .en(en), .a_valid(a_valid), .a(a_o), .result(res_o), .valid(vld_o));

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  // Reduce an exact sum to what a w-bit signed register must hold.
  function automatic longint fold(input longint v, input int w);
    longint lim, r;
    lim = longint'(1) <<< (w - 1);
`ifdef SATURATE_EN
    r = (v > lim - 1) ? lim - 1 : (v < -lim) ? -lim : v;
`else
    r = v & ((lim <<< 1) - 1);
    if (r >= lim) r = r - (lim <<< 1);
`endif
    return r;
  endfunction

  // Model state: n counts enabled cycles since reset.
  longint m_n;
  longint s_acc [4], s_res [4]; logic [3:0] s_vld;
  longint h_hold,    h_res [3]; logic [2:0] h_vld;
  longint o_acc [2], o_res [2]; logic [1:0] o_vld;

  function automatic bit fires(input longint n, input int i);
    return ((n + 1) % (longint'(BD) <<< i)) == 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_n = 0; h_hold = 0;
      s_vld = '0; h_vld = '0; o_vld = '0;
      for (int i = 0; i < 4; i++) begin s_acc[i] = 0; s_res[i] = 0; end
      for (int i = 0; i < 3; i++) h_res[i] = 0;
      for (int i = 0; i < 2; i++) begin o_acc[i] = 0; o_res[i] = 0; end
    end else begin
      longint in_s, in_o;
      s_vld = '0; h_vld = '0; o_vld = '0;
      if (en) begin
        in_s = a_valid ? longint'(a_s) : 0;
        in_o = a_valid ? longint'(a_o) : 0;
        for (int i = 0; i < 4; i++) begin
          if (fires(m_n, i)) begin
            s_res[i] = fold(s_acc[i] + in_s, 32); s_acc[i] = 0; s_vld[i] = 1'b1;
          end else s_acc[i] = fold(s_acc[i] + in_s, 32);
        end
        for (int i = 0; i < 2; i++) begin
          if (fires(m_n, i)) begin
            o_res[i] = fold(o_acc[i] + in_o, 8); o_acc[i] = 0; o_vld[i] = 1'b1;
          end else o_acc[i] = fold(o_acc[i] + in_o, 8);
        end
        for (int i = 0; i < 3; i++) begin
          if (fires(m_n, i)) begin
            h_res[i] = a_valid ? longint'(a_h) : h_hold; h_vld[i] = 1'b1;
          end
        end
        if (a_valid) h_hold = a_h;
        m_n++;
      end
    end
  end

  // Compare every DUT output with the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("sum_valid", vld_s, s_vld);
      chk("hold_valid", vld_h, h_vld);
      chk("ovf_valid", vld_o, o_vld);
      for (int i = 0; i < 4; i++)
        chk($sformatf("sum_lane%0d", i), $signed(res_s[i*32 +: 32]), s_res[i]);
      for (int i = 0; i < 3; i++)
        chk($sformatf("hold_lane%0d", i), $signed(res_h[i*16 +: 16]), h_res[i]);
      for (int i = 0; i < 2; i++)
        chk($sformatf("ovf_lane%0d", i), $signed(res_o[i*8 +: 8]), o_res[i]);
    end
  end

  int wait_n;
  bit got;
  logic signed [31:0] vals [8] = '{32'sd5, -32'sd3, 32'sd1000, -32'sd70000,
                                   32'sd0, 32'sd7, -32'sd1, 32'sd123456};

  initial begin
    chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_result", (res_s == '0 && res_h == '0 && res_o == '0), 1);
    chk("reset_valid", {vld_s, vld_h, vld_o}, 0);

    // Cadence / sample / overflow run.
    rst = 1'b1; en = 1'b1; a_valid = 1'b1; a_s = 1; a_o = 8'sd100;
    for (int c = 0; c < 40; c++) begin
      a_h = 16'(c + 1);
      @(posedge clk); #2;
      if (c == 3) begin
        chk("sum_l0_first", $signed(res_s[31:0]), 4);
        chk("hold_l0_first", $signed(res_h[15:0]), 4);
        chk("ovf_l0_first", $signed(res_o[7:0]), OVF_EXP);
      end
      if (c == 7) chk("sum_l1_first", $signed(res_s[63:32]), 8);
      if (c == 31) begin
        chk("coincident_valid", vld_s, 4'hF);
        chk("sum_l3_first", $signed(res_s[127:96]), 32);
        chk("hold_l2_coincident", $signed(res_h[47:32]), 32);
      end
    end

    // Enable freeze two cycles into a lane-0 window.
    repeat (2) begin @(posedge clk); #2; end
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #2;
      chk("freeze_no_valid", {vld_s, vld_h, vld_o}, 0);
    end
    en = 1'b1;
    wait_n = 0; got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk); #2;
      wait_n++;
      if (vld_s[0]) got = 1'b1;
    end
    chk("freeze_delay", wait_n, 2);
    chk("freeze_sum", $signed(res_s[31:0]), 4);

    // Reset two cycles into a lane-3 window (window opens at n=64).
    repeat (22) begin @(posedge clk); #2; end
    rst = 1'b0;
    #1;
    chk("midrst_result", (res_s == '0 && res_h == '0 && res_o == '0), 1);
    chk("midrst_valid", {vld_s, vld_h, vld_o}, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    for (int c = 0; c < 32; c++) begin
      a_h = 16'(c + 1);
      @(posedge clk); #2;
      if (c == 3) chk("post_rst_hold_l0", $signed(res_h[15:0]), 4);
      if (c == 31) chk("post_rst_sum_l3", $signed(res_s[127:96]), 32);
    end

    // Mixed values, sparse events and enable gaps.
    for (int c = 0; c < 200; c++) begin
      a_s = vals[c % 8];
      a_h = 16'(vals[(c + 3) % 8]);
      a_o = 8'(c * 37);
      a_valid = (c % 3) != 1;
      en = (c % 23) < 20;
      @(posedge clk); #2;
    end

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
